// File: rtl/mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe
// Description : Pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU)
//               with valid/ready handshakes, tag passthrough and flush.
//               Define MUL_PIPE_OPCACHE_EN for a one-entry product cache.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int         C_PW        = 2 * XLEN + 2;
    localparam int         C_LAST      = STAGES - 1;
    localparam logic [1:0] C_OP_MUL    = 2'd0;
    localparam logic [1:0] C_OP_MULH   = 2'd1;
    localparam logic [1:0] C_OP_MULHSU = 2'd2;

    logic              w_en;
    logic              w_shift;
    logic              w_acc;
    logic              w_acc_pipe;
    logic              w_hit;
    logic              w_a_sx;
    logic              w_b_sx;
    logic              w_pipe_out;
    logic [STAGES-1:0] r_valid;
    logic [1:0]        r_op  [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];
    logic [XLEN:0]     r_a1;
    logic [XLEN:0]     r_b1;
    logic [C_PW-1:0]   w_a_wide;
    logic [C_PW-1:0]   w_b_wide;
    logic [C_PW-1:0]   w_p0;
    logic [C_PW-1:0]   w_prod_last;
    logic [XLEN-1:0]   w_res_pipe;
    logic              w_unused_prod;

    assign w_en       = !out_valid || out_ready;
    assign w_shift    = w_en && !flush;
    assign in_ready   = w_shift;
    assign w_acc      = in_valid && in_ready;
    assign w_acc_pipe = w_acc && !w_hit;

    // Extend operands to XLEN+1 bits so one signed multiplier covers all four ops
    assign w_a_sx = ((in_op == C_OP_MULH) || (in_op == C_OP_MULHSU)) && in_a[XLEN-1];
    assign w_b_sx = (in_op == C_OP_MULH) && in_b[XLEN-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a1 <= '0;
            r_b1 <= '0;
        end else if (w_acc_pipe) begin
            r_a1 <= {w_a_sx, in_a};
            r_b1 <= {w_b_sx, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_op[s]  <= '0;
                r_tag[s] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_en) begin
            r_valid[0] <= w_acc_pipe;
            if (w_acc_pipe) begin
                r_op[0]  <= in_op;
                r_tag[0] <= in_tag;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_op[s]    <= r_op[s-1];
                r_tag[s]   <= r_tag[s-1];
            end
        end
    end

    assign w_a_wide = {{(XLEN+1){r_a1[XLEN]}}, r_a1};
    assign w_b_wide = {{(XLEN+1){r_b1[XLEN]}}, r_b1};
    assign w_p0     = w_a_wide * w_b_wide;

    generate
        if (STAGES > 1) begin : g_prod_regs
            logic [C_PW-1:0] r_prod [STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < STAGES - 1; s++) begin
                        r_prod[s] <= '0;
                    end
                end else if (w_shift) begin
                    r_prod[0] <= w_p0;
                    for (int s = 1; s < STAGES - 1; s++) begin
                        r_prod[s] <= r_prod[s-1];
                    end
                end
            end

            assign w_prod_last = r_prod[STAGES-2];
        end else begin : g_prod_comb
            assign w_prod_last = w_p0;
        end
    endgenerate

    assign w_res_pipe    = (r_op[C_LAST] == C_OP_MUL) ? w_prod_last[XLEN-1:0]
                                                      : w_prod_last[2*XLEN-1:XLEN];
    assign w_unused_prod = &{1'b0, w_prod_last[C_PW-1:2*XLEN]};
    // Outputs are masked during flush so the consumer never takes a discarded op
    assign w_pipe_out    = r_valid[C_LAST] && !flush;

`ifdef MUL_PIPE_OPCACHE_EN
    logic [XLEN-1:0]   r_sa [STAGES];
    logic [XLEN-1:0]   r_sb [STAGES];
    logic              r_c_valid;
    logic [XLEN-1:0]   r_c_a;
    logic [XLEN-1:0]   r_c_b;
    logic [1:0]        r_c_op;
    logic [2*XLEN-1:0] r_c_prod;
    logic              r_h_valid;
    logic [XLEN-1:0]   r_h_res;
    logic [TAG_W-1:0]  r_h_tag;

    // Raw operands travel alongside each op so the cache can tag its product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_sa[s] <= '0;
                r_sb[s] <= '0;
            end
        end else if (w_shift) begin
            if (w_acc_pipe) begin
                r_sa[0] <= in_a;
                r_sb[0] <= in_b;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_sa[s] <= r_sa[s-1];
                r_sb[s] <= r_sb[s-1];
            end
        end
    end

    // Low product bits are signedness-independent, so MUL may reuse any entry
    assign w_hit = in_valid && in_ready && r_c_valid && !busy &&
                   (in_a == r_c_a) && (in_b == r_c_b) &&
                   ((in_op == C_OP_MUL) || (in_op == r_c_op));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_op    <= '0;
            r_c_prod  <= '0;
        end else if (flush) begin
            r_c_valid <= 1'b0;
        end else if (w_pipe_out && out_ready) begin
            r_c_valid <= 1'b1;
            r_c_a     <= r_sa[C_LAST];
            r_c_b     <= r_sb[C_LAST];
            r_c_op    <= r_op[C_LAST];
            r_c_prod  <= w_prod_last[2*XLEN-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_valid <= 1'b0;
            r_h_res   <= '0;
            r_h_tag   <= '0;
        end else if (flush) begin
            r_h_valid <= 1'b0;
        end else if (w_en) begin
            r_h_valid <= w_hit;
            if (w_hit) begin
                r_h_res <= (in_op == C_OP_MUL) ? r_c_prod[XLEN-1:0]
                                               : r_c_prod[2*XLEN-1:XLEN];
                r_h_tag <= in_tag;
            end
        end
    end

    assign out_valid = w_pipe_out || (r_h_valid && !flush);
    assign out_res   = r_h_valid ? r_h_res : w_res_pipe;
    assign out_tag   = r_h_valid ? r_h_tag : r_tag[C_LAST];
    assign busy      = (|r_valid) || r_h_valid;
`else
    assign w_hit     = 1'b0;
    assign out_valid = w_pipe_out;
    assign out_res   = w_res_pipe;
    assign out_tag   = r_tag[C_LAST];
    assign busy      = |r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_pipe
// Description : Self-checking bench for mul_pipe: directed steps plus random
//               traffic against a 64-bit arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_tag;
    logic        busy;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   acc_flag;
    logic [31:0] held;

    mul_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit two's-complement arithmetic per op
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            2'd0:    p = ua * ub;
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        acc_flag = 1'b0;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_res", out_res, e.res);
                chk("sb_tag", out_tag, e.tag);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back({ref_mul(in_op, in_a, in_b), in_tag});
            acc_flag = 1'b1;
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        int n;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 40);
        if (!acc_flag) chk("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_res", out_res, 32'h0);
        chk("rst_out_tag", out_tag, 5'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Basic MUL latency
        send(2'd0, 32'h12345678, 32'h00000010, 5'd3);
        chk("lat_early", out_valid, 1'b0);
        step();
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_res", out_res, 32'h23456780);
        chk("lat_tag", out_tag, 5'd3);
        drain();

        // All-ones operands, back to back
        send(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
        send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
        send(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
        send(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4);
        chk("b2b_valid3", out_valid, 1'b1);
        chk("b2b_mulhsu", out_res, 32'hFFFFFFFF);
        step();
        chk("b2b_valid4", out_valid, 1'b1);
        chk("b2b_mul", out_res, 32'h00000001);
        drain();

        // Most-negative operand corners
        send(2'd1, 32'h80000000, 32'h80000000, 5'd5);
        send(2'd2, 32'h80000000, 32'h80000000, 5'd6);
        chk("mulh_min", out_res, 32'h40000000);
        step();
        chk("mulhsu_min", out_res, 32'hC0000000);
        drain();

        // Backpressure: three ops, consumer stalled for five cycles
        out_ready = 1'b0;
        send(2'd0, 32'd11, 32'd13, 5'd7);
        send(2'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd8);
        chk("stall_out_valid", out_valid, 1'b1);
        held = out_res;
        chk("stall_head_res", held, exp_q[0].res);
        in_valid = 1'b1; in_op = 2'd1; in_a = 32'h87654321; in_b = 32'h0F0F0F0F; in_tag = 5'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_hold_res", out_res, held);
            chk("stall_hold_tag", out_tag, 5'd7);
        end
        out_ready = 1'b1;
        send(2'd1, 32'h87654321, 32'h0F0F0F0F, 5'd9);
        drain();

        // Flush with a competing new op
        send(2'd0, 32'd100, 32'd200, 5'd10);
        send(2'd1, 32'd300, 32'd400, 5'd11);
        flush = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_a = 32'd5; in_b = 32'd6; in_tag = 5'd12;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_out_masked", out_valid, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", out_valid, 1'b0);
        end

`ifdef MUL_PIPE_OPCACHE_EN
        send(2'd1, 32'd7, 32'd9, 5'd13);
        drain();
        send(2'd0, 32'd7, 32'd9, 5'd14);
        chk("cache_valid", out_valid, 1'b1);
        chk("cache_res", out_res, 32'h0000003F);
        chk("cache_tag", out_tag, 5'd14);
        drain();
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            logic [31:0] corner [5];
            corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFFFFFF;
            corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            in_b      = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            in_tag    = 5'($urandom_range(0, 31));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset while ops are in flight
        send(2'd3, 32'h13579BDF, 32'h2468ACE0, 5'd15);
        send(2'd2, 32'hFEDCBA98, 32'h01234567, 5'd16);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_quiet", out_valid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
